// File: rtl/dm_hs_mem.sv
// dm_hs_mem: byte-addressed data memory with a ready/valid handshake.
// Accepts byte/half/word loads and stores and generates the byte lanes internally.
// Sub-word loads are sign- or zero-extended, and misaligned or illegal accesses are flagged.
// WAIT_CYCLES adds stall cycles between accepting a request and committing it.
// Optional build macro DM_STATS_EN adds load, store and error counters.
module dm_hs_mem #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o
`ifdef DM_STATS_EN
    ,
    output logic [31:0]       ld_cnt_o,
    output logic [31:0]       st_cnt_o,
    output logic [15:0]       err_cnt_o
`endif
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_size;
    logic              lat_sign;
    logic              lat_we;
    logic [31:0]       lat_wdata;

    logic              accept;
    logic              commit;
    logic [ADDR_W-1:0] c_addr;
    logic [1:0]        c_size;
    logic              c_sign;
    logic              c_we;
    logic [31:0]       c_wdata;
    logic              c_err;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       ld_data;
    logic [3:0]        wr_mask;
    logic [31:0]       wr_data;

    logic [31:0]       mem [DEPTH] = '{default: '0};

    assign ready_o  = (state != S_WAIT);
    assign rvalid_o = (state == S_RESP);
    assign accept   = req_i & ready_o;

    // Pick the transaction being committed this edge: the live request when there are no wait
    // states, otherwise the copy latched at accept once the wait counter runs out.
    always_comb begin
        commit  = 1'b0;
        c_addr  = lat_addr;
        c_size  = lat_size;
        c_sign  = lat_sign;
        c_we    = lat_we;
        c_wdata = lat_wdata;
        if (WAIT_CYCLES == 0) begin
            commit  = accept & rst_n;
            c_addr  = addr_i;
            c_size  = size_i;
            c_sign  = sign_i;
            c_we    = we_i;
            c_wdata = wdata_i;
        end else begin
            commit = (state == S_WAIT) && (wait_cnt == 4'd0) && rst_n;
        end
    end

    // Classify the access, build store lanes and extend the load data for the committing access.
    always_comb begin
        c_err    = (c_size == 2'd3) ||
                   ((c_size == 2'd1) && c_addr[0]) ||
                   ((c_size == 2'd2) && (c_addr[1:0] != 2'b00));
        rd_word  = mem[c_addr[ADDR_W-1:2]];
        rd_shift = rd_word >> {c_addr[1:0], 3'b000};
        wr_mask  = 4'b0000;
        wr_data  = c_wdata;
        ld_data  = rd_word;
        case (c_size)
            2'd0: begin
                wr_mask = 4'b0001 << c_addr[1:0];
                wr_data = {4{c_wdata[7:0]}};
                ld_data = c_sign ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'b0, rd_shift[7:0]};
            end
            2'd1: begin
                wr_mask = c_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{c_wdata[15:0]}};
                ld_data = c_sign ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'b0, rd_shift[15:0]};
            end
            2'd2: begin
                wr_mask = 4'b1111;
            end
            default: begin
                wr_mask = 4'b0000;
            end
        endcase
    end

    // Handshake FSM, wait counter, request capture and the registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            lat_addr  <= '0;
            lat_size  <= 2'd0;
            lat_sign  <= 1'b0;
            lat_we    <= 1'b0;
            lat_wdata <= 32'd0;
            rdata_o   <= 32'd0;
            err_o     <= 1'b0;
        end else begin
            if (accept) begin
                lat_addr  <= addr_i;
                lat_size  <= size_i;
                lat_sign  <= sign_i;
                lat_we    <= we_i;
                lat_wdata <= wdata_i;
            end
            if (commit) begin
                rdata_o <= (c_err || c_we) ? 32'd0 : ld_data;
                err_o   <= c_err;
            end else begin
                rdata_o <= 32'd0;
                err_o   <= 1'b0;
            end
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM write port: only lanes selected by the committing aligned store are updated.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[c_addr[ADDR_W-1:2]][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

`ifdef DM_STATS_EN
    // Transaction statistics, bumped at the commit edge; errors are never counted as loads/stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_o  <= 32'd0;
            st_cnt_o  <= 32'd0;
            err_cnt_o <= 16'd0;
        end else if (commit) begin
            if (c_err) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end else if (c_we) begin
                st_cnt_o <= st_cnt_o + 32'd1;
            end else begin
                ld_cnt_o <= ld_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_hs_mem.sv
// tb_dm_hs_mem: directed testbench for dm_hs_mem with one zero-wait and one three-wait instance.
// Build with DM_STATS_EN defined to also cover the statistics counters.
module tb_dm_hs_mem;

    logic        clk;
    logic        rst_n;

    logic        req0, we0, sign0;
    logic [11:0] addr0;
    logic [1:0]  size0;
    logic [31:0] wdata0;
    logic        ready0, rvalid0, err0;
    logic [31:0] rdata0;

    logic        req3, we3, sign3;
    logic [11:0] addr3;
    logic [1:0]  size3;
    logic [31:0] wdata3;
    logic        ready3, rvalid3, err3;
    logic [31:0] rdata3;

`ifdef DM_STATS_EN
    logic [31:0] ldCnt0, stCnt0, ldCnt3, stCnt3;
    logic [15:0] errCnt0, errCnt3;
`endif

    int checks = 0;
    int errors = 0;

    dm_hs_mem #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .size_i(size0), .sign_i(sign0), .wdata_i(wdata0), .ready_o(ready0),
        .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
`ifdef DM_STATS_EN
        , .ld_cnt_o(ldCnt0), .st_cnt_o(stCnt0), .err_cnt_o(errCnt0)
`endif
    );

    dm_hs_mem #(.ADDR_W(12), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(req3), .we_i(we3), .addr_i(addr3),
        .size_i(size3), .sign_i(sign3), .wdata_i(wdata3), .ready_o(ready3),
        .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3)
`ifdef DM_STATS_EN
        , .ld_cnt_o(ldCnt3), .st_cnt_o(stCnt3), .err_cnt_o(errCnt3)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request to the zero-wait instance and steps just past the accepting edge.
    task automatic applyStimulus(input logic we, input logic [11:0] addr, input logic [1:0] size,
                                 input logic sign, input logic [31:0] wdata);
        req0   = 1'b1;
        we0    = we;
        addr0  = addr;
        size0  = size;
        sign0  = sign;
        wdata0 = wdata;
        @(posedge clk);
        #1;
    endtask

    // Checks the response pulse that follows a zero-wait accept.
    task automatic checkResp0(input string tag, input logic [31:0] expData, input logic expErr);
        checkOutput({tag, "_rvalid"}, {31'b0, rvalid0}, 32'd1);
        checkOutput({tag, "_rdata"}, rdata0, expData);
        checkOutput({tag, "_err"}, {31'b0, err0}, {31'b0, expErr});
    endtask

    // Drives one request to the three-wait instance and follows it to its response (bounded).
    task automatic runWait3(input string tag, input logic we, input logic [11:0] addr,
                            input logic [1:0] size, input logic [31:0] wdata,
                            input logic [31:0] expData, input logic expErr);
        bit seen;
        req3   = 1'b1;
        we3    = we;
        addr3  = addr;
        size3  = size;
        sign3  = 1'b0;
        wdata3 = wdata;
        @(posedge clk);
        #1;
        req3 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rvalid3) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_seen"}, {31'b0, seen}, 32'd1);
        checkOutput({tag, "_rdata"}, rdata3, expData);
        checkOutput({tag, "_err"}, {31'b0, err3}, {31'b0, expErr});
        @(posedge clk);
        #1;
    endtask

    // Directed test sequence.
    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; size0 = 2'd0; sign0 = 1'b0; wdata0 = '0;
        req3 = 1'b0; we3 = 1'b0; addr3 = '0; size3 = 2'd0; sign3 = 1'b0; wdata3 = '0;
        #2;
        checkOutput("rst_ready0", {31'b0, ready0}, 32'd1);
        checkOutput("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
        checkOutput("rst_rdata0", rdata0, 32'd0);
        checkOutput("rst_err0", {31'b0, err0}, 32'd0);
        checkOutput("rst_ready3", {31'b0, ready3}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] zero-wait instance");
        applyStimulus(1'b1, 12'h010, 2'd2, 1'b0, 32'h11223344);
        checkResp0("st_w010", 32'h0, 1'b0);
        applyStimulus(1'b0, 12'h010, 2'd2, 1'b0, 32'h0);
        checkResp0("ld_w010", 32'h11223344, 1'b0);
        applyStimulus(1'b1, 12'h013, 2'd0, 1'b0, 32'h00000080);
        checkResp0("st_b013", 32'h0, 1'b0);
        applyStimulus(1'b0, 12'h013, 2'd0, 1'b1, 32'h0);
        checkResp0("ld_b013_s", 32'hFFFFFF80, 1'b0);
        applyStimulus(1'b0, 12'h013, 2'd0, 1'b0, 32'h0);
        checkResp0("ld_b013_z", 32'h00000080, 1'b0);
        applyStimulus(1'b0, 12'h010, 2'd2, 1'b1, 32'h0);
        checkResp0("ld_w010_b", 32'h80223344, 1'b0);
        applyStimulus(1'b0, 12'h012, 2'd1, 1'b1, 32'h0);
        checkResp0("ld_h012_s", 32'hFFFF8022, 1'b0);
        applyStimulus(1'b0, 12'h011, 2'd0, 1'b1, 32'h0);
        checkResp0("ld_b011_s", 32'h00000033, 1'b0);
        applyStimulus(1'b1, 12'h012, 2'd1, 1'b0, 32'h0000BEEF);
        checkResp0("st_h012", 32'h0, 1'b0);
        applyStimulus(1'b0, 12'h010, 2'd2, 1'b0, 32'h0);
        checkResp0("ld_w010_c", 32'hBEEF3344, 1'b0);
        applyStimulus(1'b1, 12'h022, 2'd2, 1'b0, 32'hA5A5A5A5);
        checkResp0("st_w022_mis", 32'h0, 1'b1);
        applyStimulus(1'b0, 12'h020, 2'd3, 1'b1, 32'h0);
        checkResp0("ld_sz3_020", 32'h0, 1'b1);
        applyStimulus(1'b0, 12'h020, 2'd2, 1'b0, 32'h0);
        checkResp0("ld_w020", 32'h0, 1'b0);
        applyStimulus(1'b0, 12'h013, 2'd1, 1'b0, 32'h0);
        checkResp0("ld_h013_mis", 32'h0, 1'b1);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_rvalid0", {31'b0, rvalid0}, 32'd0);
        checkOutput("idle_ready0", {31'b0, ready0}, 32'd1);
`ifdef DM_STATS_EN
        checkOutput("stat_ld0", ldCnt0, 32'd8);
        checkOutput("stat_st0", stCnt0, 32'd3);
        checkOutput("stat_err0", {16'b0, errCnt0}, 32'd3);
`endif

        $display("[TB] three-wait instance");
        runWait3("w3_st004", 1'b1, 12'h004, 2'd2, 32'hCAFEF00D, 32'h0, 1'b0);

        req3 = 1'b1; we3 = 1'b0; addr3 = 12'h004; size3 = 2'd2; wdata3 = 32'h0;
        @(posedge clk);
        #1;
        checkOutput("lat_c1_ready", {31'b0, ready3}, 32'd0);
        checkOutput("lat_c1_rvalid", {31'b0, rvalid3}, 32'd0);
        we3 = 1'b1; addr3 = 12'h008; wdata3 = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req3 = 1'b0;
        checkOutput("lat_c2_ready", {31'b0, ready3}, 32'd0);
        checkOutput("lat_c2_rvalid", {31'b0, rvalid3}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_c3_ready", {31'b0, ready3}, 32'd0);
        checkOutput("lat_c3_rvalid", {31'b0, rvalid3}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_c4_rvalid", {31'b0, rvalid3}, 32'd1);
        checkOutput("lat_c4_ready", {31'b0, ready3}, 32'd1);
        checkOutput("lat_c4_rdata", rdata3, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        checkOutput("lat_c5_rvalid", {31'b0, rvalid3}, 32'd0);
        runWait3("w3_ld008", 1'b0, 12'h008, 2'd2, 32'h0, 32'h0, 1'b0);

        req3 = 1'b1; we3 = 1'b1; addr3 = 12'h004; size3 = 2'd2; wdata3 = 32'h12345678;
        @(posedge clk);
        #1;
        req3 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre_rst_ready3", {31'b0, ready3}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ready3", {31'b0, ready3}, 32'd1);
        checkOutput("mid_rst_rvalid3", {31'b0, rvalid3}, 32'd0);
        checkOutput("mid_rst_rdata3", rdata3, 32'd0);
        checkOutput("mid_rst_err3", {31'b0, err3}, 32'd0);
`ifdef DM_STATS_EN
        checkOutput("rst_stat_ld3", ldCnt3, 32'd0);
        checkOutput("rst_stat_st3", stCnt3, 32'd0);
        checkOutput("rst_stat_err3", {16'b0, errCnt3}, 32'd0);
        checkOutput("rst_stat_ld0", ldCnt0, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        runWait3("w3_ld004_after_rst", 1'b0, 12'h004, 2'd2, 32'h0, 32'hCAFEF00D, 1'b0);
        runWait3("w3_st_mis", 1'b1, 12'h006, 2'd2, 32'hFFFFFFFF, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
